dsc_s2b_rx: RTL and testbench
=============================

# dsc_s2b_rx

Stochastic-to-binary receiver for the deterministic stochastic computing (DSC) datapath. It consumes the serial product bitstream from a DSC multiplier and the upstream early-shutoff flag. It counts ones over a full deterministic window of 2^(NUM_INPUTS·SNG_WIDTH) cycles, or until shutoff, and returns the binary result through a valid/ready handshake. It replaces the free-running output counter, so results are framed, held and acknowledged instead of read asynchronously.

## Interface
- SNG_WIDTH, 8, bit width of each SNG operand
- NUM_INPUTS, 3, number of multiplied stochastic operands
- OUT_WIDTH, NUM_INPUTS*SNG_WIDTH, result width; the window is 2^OUT_WIDTH samples

- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- start  input  1  request a new conversion; accepted in IDLE, or in DONE together with z_ready
- sn_in  input  1  stochastic product bit, sampled every RUN cycle
- stop  input  1  upstream early-shutoff (ov) flag
- z  output  OUT_WIDTH  binary result (count of ones), registered
- z_valid  output  1  result available
- z_ready  input  1  consumer acknowledge
- sat  output  1  count exceeded 2^OUT_WIDTH−1; z is clamped
- busy  output  1  high in RUN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: an edge with start=1 clears acc and win, then goes to RUN.
- RUN: each edge does win += 1 and acc += sn_in.
  - acc is OUT_WIDTH+1 bits.
  - win is an OUT_WIDTH-bit counter.
  - When win == 2^OUT_WIDTH−1, that edge's sample is the last one. Go to DONE.
  - On the DONE transition, z is loaded with acc_next, clamped to all-ones, and sat = acc_next[OUT_WIDTH].
- Early stop (macro enabled): if stop=1 on a RUN edge, that edge's sn_in is NOT counted. Go to DONE with z = acc.
- DONE: z_valid=1. z and sat are held stable until an edge with z_ready=1.
  - z_ready=1 and start=0: go to IDLE. z_valid drops; z and sat keep their last values.
  - z_ready=1 and start=1: go straight to RUN with acc and win cleared (back-to-back conversion).
- start is ignored in RUN, and in DONE without z_ready.
- z_ready outside DONE is ignored.
- Reset mid-operation aborts the conversion. No partial result is emitted.

## Timing
- Reset values: z=0, z_valid=0, sat=0, busy=0, state=IDLE, acc=0, win=0.
- Start edge k: sn_in is sampled on edges k+1 … k+2^OUT_WIDTH.
- z_valid rises on edge k+2^OUT_WIDTH, the same edge as the last sample.
- Latency from start to z_valid is 2^OUT_WIDTH cycles.
- Early stop at edge j puts z_valid high from edge j onward.
- Minimum period between results in back-to-back mode is 2^OUT_WIDTH+1 cycles.
- busy is high exactly for the edges on which a sample is taken.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- DSC_S2B_EARLY_STOP_EN defined: the stop input terminates RUN as described in Operation.
- DSC_S2B_EARLY_STOP_EN undefined: stop is ignored (left unconnected internally), and every conversion runs the full window.

## Structure
- Shared package dsc_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default SNG_WIDTH and NUM_INPUTS constants;
  - the OUT_WIDTH derivation.
- One sub-module, s2b_window_ctr, holds win with clear/enable and a terminal-count output. The FSM and accumulator stay in the top module.

## Test plan
All scenarios use SNG_WIDTH=2, NUM_INPUTS=2, giving OUT_WIDTH=4 and a 16-cycle window.
- Reset, then idle 5 cycles → z=0, z_valid=0, sat=0, busy=0.
- Start at edge 0, sn_in=1 on 5 of the 16 samples → z_valid rises at edge 16, z=5, sat=0. Hold z_ready=0 for 3 cycles → z stays 5. Pulse z_ready → IDLE.
- Start, sn_in=1 on all 16 samples → z=4'hF, sat=1.
- Macro defined, stop=1 on the 4th sample edge, sn_in=1 throughout → z=3 at that edge. Macro undefined, same stimulus → z=4'hF, sat=1 at edge 16.
- In DONE, z_ready=1 and start=1 on the same edge; next window has 7 ones → z_valid falls for 16 cycles, then the second result is z=7.
- Drive rst=0 at sample 9 of a run, release it, then start a run with 2 ones → outputs go to 0 asynchronously, no stale result appears, and the new run gives z=2.

Source files
------------

// File: rtl/dsc_pkg.sv
// -----------------------------------------------------------------------------
// dsc_pkg
// Shared definitions for the deterministic stochastic computing (DSC) datapath.
//   - default operand width and operand count for the DSC multiplier
//   - out_width(): binary result width derived from those two
//   - s2b_state_e: control states of the stochastic-to-binary receiver
// -----------------------------------------------------------------------------
package dsc_pkg;

  localparam int SNG_WIDTH_DEF  = 8;
  localparam int NUM_INPUTS_DEF = 3;

  // The deterministic window enumerates every combination of the operand
  // SNG states, so the count width is the sum of all operand widths.
  function automatic int out_width(input int sng_width, input int num_inputs);
    return sng_width * num_inputs;
  endfunction

  localparam int OUT_WIDTH_DEF = out_width(SNG_WIDTH_DEF, NUM_INPUTS_DEF);

  // Explicit encoding keeps the state values stable across tool versions.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } s2b_state_e;

endpackage

// File: rtl/s2b_window_ctr.sv
// -----------------------------------------------------------------------------
// s2b_window_ctr
// Sample-window counter for the stochastic-to-binary receiver.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (has priority over en)
//   en       : count one sample
//   tc       : terminal count, high while the counter holds all-ones, i.e. the
//              sample counted on the next enabled edge is the last of the window
// -----------------------------------------------------------------------------
module s2b_window_ctr #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] win;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win <= '0;
    end else if (clr) begin
      win <= '0;
    end else if (en) begin
      win <= win + WIDTH'(1);
    end
  end

  assign tc = &win;

endmodule

// File: rtl/dsc_s2b_rx.sv
// -----------------------------------------------------------------------------
// dsc_s2b_rx
// Stochastic-to-binary receiver. Counts ones on the serial DSC product stream
// over a full 2^OUT_WIDTH-sample window (or until upstream shutoff) and hands
// the count to a consumer through a valid/ready handshake.
//
// Build option:
//   DSC_S2B_EARLY_STOP_EN - when defined, stop=1 on a sampling edge ends the
//                           window without counting that edge's sample.
//                           When undefined, stop is ignored.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   start    : request a conversion (taken in IDLE, or in DONE with z_ready)
//   sn_in    : stochastic product bit, sampled on every RUN edge
//   stop     : upstream early-shutoff flag
//   z        : registered result (count of ones, clamped to all-ones)
//   z_valid  : result available, held until z_ready
//   z_ready  : consumer acknowledge
//   sat      : count overflowed OUT_WIDTH bits; z is clamped
//   busy     : high on exactly the edges that take a sample
// -----------------------------------------------------------------------------
module dsc_s2b_rx
  import dsc_pkg::*;
#(
  parameter int SNG_WIDTH  = SNG_WIDTH_DEF,
  parameter int NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int OUT_WIDTH  = out_width(SNG_WIDTH, NUM_INPUTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sn_in,
  input  logic                 stop,
  output logic [OUT_WIDTH-1:0] z,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic                 sat,
  output logic                 busy
);

  s2b_state_e           state;
  logic [OUT_WIDTH:0]   acc;
  logic [OUT_WIDTH:0]   acc_next;
  logic                 stop_hit;
  logic                 start_run;
  logic                 win_en;
  logic                 win_tc;

`ifdef DSC_S2B_EARLY_STOP_EN
  assign stop_hit = stop;
`else
  // stop has no function in this build; it is tied off here on purpose.
  logic stop_unused;
  assign stop_unused = stop;
  assign stop_hit    = 1'b0;
`endif

  // One extra accumulator bit so a window of all ones is detected as overflow.
  assign acc_next  = acc + {{OUT_WIDTH{1'b0}}, sn_in};

  assign start_run = start && ((state == ST_IDLE) || ((state == ST_DONE) && z_ready));
  assign win_en    = (state == ST_RUN) && !stop_hit;

  s2b_window_ctr #(
    .WIDTH (OUT_WIDTH)
  ) u_window_ctr (
    .clk (clk),
    .rst (rst),
    .clr (start_run),
    .en  (win_en),
    .tc  (win_tc)
  );

  // NOTE: the accumulator is reset along with the control state so that an
  // aborted conversion can never leak a partial count into the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      z       <= '0;
      z_valid <= 1'b0;
      sat     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop_hit) begin
            // Stopped before the last sample, so acc cannot have overflowed.
            z       <= acc[OUT_WIDTH-1:0];
            sat     <= 1'b0;
            z_valid <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_DONE;
          end else begin
            acc <= acc_next;
            if (win_tc) begin
              z       <= acc_next[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : acc_next[OUT_WIDTH-1:0];
              sat     <= acc_next[OUT_WIDTH];
              z_valid <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (z_ready) begin
            // z and sat keep their last values after the handshake.
            z_valid <= 1'b0;
            if (start) begin
              acc   <= '0;
              busy  <= 1'b1;
              state <= ST_RUN;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_s2b_rx.sv
// -----------------------------------------------------------------------------
// tb_dsc_s2b_rx
// Self-checking bench for dsc_s2b_rx with SNG_WIDTH=2, NUM_INPUTS=2
// (OUT_WIDTH=4, 16-sample window). Honours DSC_S2B_EARLY_STOP_EN.
// -----------------------------------------------------------------------------
module tb_dsc_s2b_rx;

  localparam int OW  = 4;
  localparam int WIN = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sn_in;
  logic          stop;
  logic          z_ready;
  logic [OW-1:0] z;
  logic          z_valid;
  logic          sat;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsc_s2b_rx #(
    .SNG_WIDTH  (2),
    .NUM_INPUTS (2),
    .OUT_WIDTH  (OW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sn_in   (sn_in),
    .stop    (stop),
    .z       (z),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .sat     (sat),
    .busy    (busy)
  );

  typedef struct {
    logic [WIN-1:0] bits;     // bits[i] is driven on sample edge i
    int             stop_at;  // sample index carrying stop=1, -1 for none
    logic [OW-1:0]  exp_z;
    logic           exp_sat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: count the ones that belong to the window, then clamp.
  task automatic model(input logic [WIN-1:0] bits, input int stop_at,
                       output logic [OW-1:0] mz, output logic msat);
    int n   = WIN;
    int cnt = 0;
`ifdef DSC_S2B_EARLY_STOP_EN
    if (stop_at >= 0) n = stop_at;
`endif
    for (int i = 0; i < n; i++) cnt += int'(bits[i]);
    if (cnt > WIN - 1) begin
      mz   = '1;
      msat = 1'b1;
    end else begin
      mz   = OW'(cnt);
      msat = 1'b0;
    end
  endtask

  task automatic start_conv();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_valid", z_valid, 0);
  endtask

  // Drive one window of samples; optional noise on start/z_ready must be ignored.
  task automatic feed(input logic [WIN-1:0] bits, input int stop_at, input bit noise,
                      input logic [OW-1:0] exp_z, input logic exp_sat);
    int last = WIN - 1;
`ifdef DSC_S2B_EARLY_STOP_EN
    if (stop_at >= 0) last = stop_at;
`endif
    for (int i = 0; i <= last; i++) begin
      sn_in = bits[i];
      stop  = (i == stop_at);
      if (noise) begin
        start   = 1'($urandom);
        z_ready = 1'($urandom);
      end
      tick();
      if (i < last) begin
        check("run_busy", busy, 1);
        check("run_valid", z_valid, 0);
      end
    end
    sn_in   = 1'b0;
    stop    = 1'b0;
    start   = 1'b0;
    z_ready = 1'b0;
    check("done_valid", z_valid, 1);
    check("done_busy", busy, 0);
    check("result_z", z, exp_z);
    check("result_sat", sat, exp_sat);
  endtask

  task automatic ack(input logic [OW-1:0] held_z);
    z_ready = 1'b1;
    tick();
    z_ready = 1'b0;
    check("ack_valid", z_valid, 0);
    check("ack_busy", busy, 0);
    check("ack_z_held", z, held_z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t           vecs [5];
    logic [WIN-1:0] rbits;
    int             rstop;
    logic [OW-1:0]  mz;
    logic           msat;
    int             stale;

    rst     = 1'b0;
    start   = 1'b0;
    sn_in   = 1'b0;
    stop    = 1'b0;
    z_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;

    // Reset state; z_ready while idle must have no effect.
    z_ready = 1'b1;
    repeat (5) tick();
    z_ready = 1'b0;
    check("reset_z", z, 0);
    check("reset_valid", z_valid, 0);
    check("reset_sat", sat, 0);
    check("reset_busy", busy, 0);

    vecs[0] = '{bits: 16'h1431, stop_at: -1, exp_z: 4'd5,  exp_sat: 1'b0};
    vecs[1] = '{bits: 16'hFFFF, stop_at: -1, exp_z: 4'hF,  exp_sat: 1'b1};
    vecs[2] = '{bits: 16'hFFFE, stop_at: -1, exp_z: 4'hF,  exp_sat: 1'b0};
    vecs[3] = '{bits: 16'h0000, stop_at: -1, exp_z: 4'd0,  exp_sat: 1'b0};
`ifdef DSC_S2B_EARLY_STOP_EN
    vecs[4] = '{bits: 16'hFFFF, stop_at: 3,  exp_z: 4'd3,  exp_sat: 1'b0};
`else
    vecs[4] = '{bits: 16'hFFFF, stop_at: 3,  exp_z: 4'hF,  exp_sat: 1'b1};
`endif

    for (int v = 0; v < 5; v++) begin
      start_conv();
      feed(vecs[v].bits, vecs[v].stop_at, 1'b0, vecs[v].exp_z, vecs[v].exp_sat);
      ack(vecs[v].exp_z);
    end

    // Result is held while z_ready is low; start without z_ready is ignored.
    start_conv();
    feed(16'h1431, -1, 1'b0, 4'd5, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_z", z, 5);
      check("hold_valid", z_valid, 1);
      check("hold_busy", busy, 0);
    end
    start = 1'b0;
    ack(4'd5);

    // Back-to-back: acknowledge and restart on the same edge.
    start_conv();
    feed(16'h1431, -1, 1'b0, 4'd5, 1'b0);
    z_ready = 1'b1;
    start   = 1'b1;
    tick();
    z_ready = 1'b0;
    start   = 1'b0;
    check("b2b_valid", z_valid, 0);
    check("b2b_busy", busy, 1);
    feed(16'h70F0, -1, 1'b0, 4'd7, 1'b0);
    ack(4'd7);

    // Reset during sample 9 aborts the run asynchronously.
    start_conv();
    sn_in = 1'b1;
    repeat (8) tick();
    check("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", z_valid, 0);
    check("async_rst_z", z, 0);
    check("async_rst_sat", sat, 0);
    sn_in = 1'b0;
    repeat (2) tick();
    rst   = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (z_valid || busy) stale++;
    end
    check("no_stale_result", stale, 0);
    start_conv();
    feed(16'h0101, -1, 1'b0, 4'd2, 1'b0);
    ack(4'd2);

    // Randomized windows against the reference model.
    for (int r = 0; r < 30; r++) begin
      rbits = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rbits = 16'hFFFF;
      rstop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIN - 1)) : -1;
      model(rbits, rstop, mz, msat);
      start_conv();
      feed(rbits, rstop, 1'b1, mz, msat);
      ack(mz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
